// File: rtl/seq_signed_or_unsigned_mul_pkg.sv
// ============================================================================
// Module : seq_mul_pkg
// Brief  : State encoding and counter-width helper for the sequential multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // The iteration counter must be able to hold the value n itself.
   function automatic int COUNT_W(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_signed_or_unsigned_mul_if.sv
// ============================================================================
// Module : seq_signed_or_unsigned_mul_if
// Brief  : Request/result valid-ready bundle of the sequential multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_signed_or_unsigned_mul_if #(
   parameter int N = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           sign;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] res;
   logic           busy;

   modport master (
      output in_valid, a, b, sign, out_ready,
      input  in_ready, out_valid, res, busy
   );

   modport slave (
      input  in_valid, a, b, sign, out_ready,
      output in_ready, out_valid, res, busy
   );
endinterface

`default_nettype wire

// File: rtl/seq_signed_or_unsigned_mul_negate.sv
// ============================================================================
// Module : mul_cond_negate
// Brief  : Conditional two's complement negation, out = neg ? -in : in.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_cond_negate #(
   parameter int W = 8
) (
   input  wire logic         neg_i,
   input  wire logic [W-1:0] in_i,
   output logic      [W-1:0] out_o
);
   assign out_o = neg_i ? (~in_i + 1'b1) : in_i;
endmodule

`default_nettype wire

// File: rtl/seq_signed_or_unsigned_mul.sv
// ============================================================================
// Module : seq_signed_or_unsigned_mul
// Brief  : Iterative shift-add N x N -> 2N multiplier, signed or unsigned.
//          Define MUL_EARLY_TERM_EN to end CALC once the multiplier is exhausted.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_signed_or_unsigned_mul
   import seq_mul_pkg::*;
#(
   parameter int N = 8
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   seq_signed_or_unsigned_mul_if.slave bus
);
   localparam int             CW  = COUNT_W(N);
   localparam logic [CW-1:0]  C_N = CW'(N);

   state_t           state_q, state_d;
   logic [2*N-1:0]   mcand_q;
   logic [N-1:0]     mplier_q;
   logic [2*N-1:0]   acc_q;
   logic             neg_q;
   logic [CW-1:0]    count_q;
   logic [2*N-1:0]   res_q;

   logic [N-1:0]     w_mag_a;
   logic [N-1:0]     w_mag_b;
   logic             w_neg_op;
   logic             w_accept;
   logic [2*N-1:0]   w_acc_d;
   logic [N-1:0]     w_mplier_sh;
   logic [CW-1:0]    w_count_inc;
   logic             w_calc_last;
   logic [2*N-1:0]   w_res_d;

   mul_cond_negate #(.W(N)) u_neg_a (
      .neg_i (bus.sign & bus.a[N-1]),
      .in_i  (bus.a),
      .out_o (w_mag_a)
   );

   mul_cond_negate #(.W(N)) u_neg_b (
      .neg_i (bus.sign & bus.b[N-1]),
      .in_i  (bus.b),
      .out_o (w_mag_b)
   );

   mul_cond_negate #(.W(2*N)) u_neg_res (
      .neg_i (neg_q),
      .in_i  (w_acc_d),
      .out_o (w_res_d)
   );

   assign w_neg_op    = bus.sign & (bus.a[N-1] ^ bus.b[N-1]);
   assign w_accept    = bus.in_valid && (state_q == IDLE);
   // Multiplicand shifts left instead of the accumulator shifting right, so an
   // early stop leaves a fully aligned product in acc.
   assign w_acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign w_mplier_sh = mplier_q >> 1;
   assign w_count_inc = count_q + 1'b1;

`ifdef MUL_EARLY_TERM_EN
   assign w_calc_last = (w_mplier_sh == '0) || (w_count_inc == C_N);
`else
   assign w_calc_last = (w_count_inc == C_N);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (w_accept)      state_d = CALC;
         CALC:    if (w_calc_last)   state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.res       = res_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         count_q  <= '0;
         res_q    <= '0;
      end else if (w_accept) begin
         mcand_q  <= {{N{1'b0}}, w_mag_a};
         mplier_q <= w_mag_b;
         acc_q    <= '0;
         neg_q    <= w_neg_op;
         count_q  <= '0;
      end else if (state_q == CALC) begin
         acc_q    <= w_acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= w_mplier_sh;
         count_q  <= w_count_inc;
         if (w_calc_last) begin
            res_q <= w_res_d;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_signed_or_unsigned_mul.sv
// ============================================================================
// Module : tb_seq_signed_or_unsigned_mul
// Brief  : Self-checking bench, N=4, directed cases plus all operand pairs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_signed_or_unsigned_mul;
   localparam int N = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   seq_signed_or_unsigned_mul_if #(.N(N)) bus ();

   seq_signed_or_unsigned_mul #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic s);
      int ia, ib, p;
      if (s) begin
         ia = int'($signed(a));
         ib = int'($signed(b));
      end else begin
         ia = int'(a);
         ib = int'(b);
      end
      p = ia * ib;
      return p[2*N-1:0];
   endfunction

   // Cycles from accept to out_valid.
   function automatic int ref_lat(input logic [N-1:0] b, input logic s);
      int mb, lat;
      mb = (s && b[N-1]) ? -int'($signed(b)) : int'(b);
`ifdef MUL_EARLY_TERM_EN
      lat = 1;
      while ((mb >> lat) != 0) lat++;
`else
      lat = N;
`endif
      return lat;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        input logic [2*N-1:0] exp, input int gap, input int hold);
      int lat;
      logic [2*N-1:0] held;
      bus.in_valid = 1'b0;
      for (int i = 0; i < gap; i++) tick();
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.sign = s;
      tick();
      bus.in_valid = 1'b0;
      bus.a = N'($urandom);
      bus.b = N'($urandom);
      bus.sign = 1'($urandom);
      chk("busy_calc", {bus.busy, bus.in_ready, bus.out_valid}, 32'b100);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk("latency", 32'(lat), 32'(ref_lat(b, s)));
      chk("res", 32'(bus.res), 32'(exp));
      held = bus.res;
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         tick();
         chk("hold_stable", {bus.out_valid, bus.in_ready, 8'(bus.res)}, {2'b10, 8'(held)});
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("after_handshake", {bus.in_ready, bus.out_valid}, 32'b10);
   endtask

   initial begin
      int seen_valid;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.sign = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      chk("reset_state", {bus.in_ready, bus.out_valid, bus.busy, 8'(bus.res)}, {3'b100, 8'h00});
      tick();
      rst = 1'b0;
      tick();

      do_op(4'hF, 4'hF, 1'b0, 8'hE1, 0, 3);
      do_op(4'h8, 4'h8, 1'b1, 8'h40, 1, 0);
      do_op(4'h8, 4'h7, 1'b1, 8'hC8, 0, 1);
      do_op(4'h0, 4'hF, 1'b1, 8'h00, 2, 0);
      do_op(4'h7, 4'h0, 1'b0, 8'h00, 0, 0);
      do_op(4'h7, 4'h1, 1'b0, 8'h07, 0, 0);
      do_op(4'h3, 4'h8, 1'b0, 8'h18, 0, 0);

      // Reset mid-computation must discard the result.
      bus.in_valid = 1'b1;
      bus.a = 4'd5;
      bus.b = 4'd3;
      bus.sign = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rst_async", {bus.in_ready, bus.busy, 8'(bus.res)}, {2'b10, 8'h00});
      tick();
      rst = 1'b0;
      seen_valid = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.out_valid) seen_valid++;
      end
      chk("rst_no_valid", 32'(seen_valid), 32'd0);
      chk("rst_idle", {bus.in_ready, 8'(bus.res)}, {1'b1, 8'h00});
      do_op(4'd2, 4'd3, 1'b0, 8'd6, 0, 0);

      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 256; i++) begin
            logic [N-1:0] ta, tb;
            ta = N'(i >> N);
            tb = N'(i);
            do_op(ta, tb, 1'(m), ref_mul(ta, tb, 1'(m)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
